// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the DCT front-end sequencer.
package dct_pkg;
   localparam int DCT_N    = 8;
   localparam int SAMPLE_W = 8;
   localparam int COEF_W   = 19;
   localparam int IDX_W    = $clog2(DCT_N);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_CAPT
   } dct_seq_state_t;
endpackage

// File: rtl/dct_block_sequencer_serializer.sv
// Holds one captured coefficient block and streams it out in index order.
module dct_coef_serializer
   import dct_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      capture_i,
   input  logic [DCT_N*COEF_W-1:0]   z_i,
   output logic                      busy_o,
   output logic                      m_valid_o,
   output logic [COEF_W-1:0]         m_data_o,
   output logic [IDX_W-1:0]          m_idx_o,
   output logic                      m_last_o,
   input  logic                      m_ready_i
);
   logic [DCT_N-1:0][COEF_W-1:0] z;
   logic [DCT_N-1:0][COEF_W-1:0] obuf_q, obuf_d;
   logic                         busy_q, busy_d;
   logic [IDX_W-1:0]             idx_q, idx_d;

   assign z = z_i;

   always_comb begin
      obuf_d = obuf_q;
      busy_d = busy_q;
      idx_d  = idx_q;
      if (capture_i) begin
         obuf_d = z;
         busy_d = 1'b1;
         idx_d  = '0;
      end else if (busy_q && m_ready_i) begin
         // index wraps to 0 on its own after the last beat
         idx_d = idx_q + 1'b1;
         if (idx_q == IDX_W'(DCT_N - 1)) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         obuf_q <= '0;
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         obuf_q <= obuf_d;
         busy_q <= busy_d;
         idx_q  <= idx_d;
      end
   end

   assign busy_o    = busy_q;
   assign m_valid_o = busy_q;
   assign m_data_o  = obuf_q[idx_q];
   assign m_idx_o   = idx_q;
   assign m_last_o  = (idx_q == IDX_W'(DCT_N - 1));
endmodule

// File: rtl/dct_block_sequencer.sv
// Collects 8-sample blocks, sequences the DCT array, and hands the
// coefficients to the serializer; collection overlaps compute and drain.
module dct_block_sequencer
   import dct_pkg::*;
#(
   parameter int DCT_LAT = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   input  logic [SAMPLE_W-1:0]       s_data,
   output logic                      s_ready,
   output logic [DCT_N*SAMPLE_W-1:0] dct_x,
   output logic                      dct_rst_n,
   output logic                      dct_en,
   output logic                      dct_cs,
   input  logic [DCT_N*COEF_W-1:0]   dct_z,
   output logic                      m_valid,
   output logic [COEF_W-1:0]         m_data,
   output logic [IDX_W-1:0]          m_idx,
   output logic                      m_last,
   input  logic                      m_ready
);
   localparam int RUN_W = (DCT_LAT > 1) ? $clog2(DCT_LAT) : 1;

   dct_seq_state_t                state_q, state_d;
   logic [RUN_W-1:0]              run_cnt_q, run_cnt_d;
   logic                          rst_n_q;
   logic                          alive_q;
   logic [IDX_W-1:0]              wr_cnt_q, wr_cnt_d;
   logic                          coll_full_q, coll_full_d;
   logic [DCT_N-1:0][SAMPLE_W-1:0] cbuf_q, cbuf_d;
   logic [DCT_N-1:0][SAMPLE_W-1:0] x_q;
   logic                          accept, load, capture, out_busy;

   assign s_ready = alive_q & ~coll_full_q & ~rst;
   assign accept  = s_valid & s_ready;

   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      coll_full_d = coll_full_q;
      cbuf_d      = cbuf_q;
      if (load) begin
         wr_cnt_d    = '0;
         coll_full_d = 1'b0;
      end else if (accept) begin
         cbuf_d[wr_cnt_q] = s_data;
         wr_cnt_d         = wr_cnt_q + 1'b1;
         if (wr_cnt_q == IDX_W'(DCT_N - 1)) coll_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alive_q     <= 1'b0;
         wr_cnt_q    <= '0;
         coll_full_q <= 1'b0;
         cbuf_q      <= '0;
         x_q         <= '0;
      end else begin
         alive_q     <= 1'b1;
         wr_cnt_q    <= wr_cnt_d;
         coll_full_q <= coll_full_d;
         cbuf_q      <= cbuf_d;
         if (load) x_q <= cbuf_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         run_cnt_q <= '0;
         rst_n_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         rst_n_q   <= (state_d != ST_LOAD);
      end
   end

   always_comb begin
      state_d   = state_q;
      run_cnt_d = '0;
      unique case (state_q)
         ST_IDLE: if (coll_full_q && !out_busy) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            run_cnt_d = run_cnt_q + 1'b1;
            if (run_cnt_q == RUN_W'(DCT_LAT - 1)) state_d = ST_CAPT;
         end
         ST_CAPT: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      load    = 1'b0;
      capture = 1'b0;
      dct_en  = 1'b0;
      dct_cs  = 1'b0;
      unique case (state_q)
         ST_LOAD: load = 1'b1;
         ST_RUN: begin
            dct_en = 1'b1;
            dct_cs = 1'b1;
         end
         ST_CAPT: capture = 1'b1;
         default: ;
      endcase
   end

   assign dct_x     = x_q;
   assign dct_rst_n = rst_n_q;

   dct_coef_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .capture_i (capture),
      .z_i       (dct_z),
      .busy_o    (out_busy),
      .m_valid_o (m_valid),
      .m_data_o  (m_data),
      .m_idx_o   (m_idx),
      .m_last_o  (m_last),
      .m_ready_i (m_ready)
   );
endmodule
